// File: rtl/coo_stream_matmul.sv
// Streaming COO sparse X times dense Y: each accepted entry is MACed across K lanes into an N*K bank.
// Optional macro COO_STREAM_MATMUL_IDX_CHECK_EN drops out-of-range entries and raises a sticky idx_err.
module coo_stream_matmul #(
  parameter int N               = 2,
  parameter int M               = 2,
  parameter int K               = 2,
  parameter int X_WIDTH         = 8,
  parameter int X_FRAC_WIDTH    = 0,
  parameter int Y_WIDTH         = 8,
  parameter int Y_FRAC_WIDTH    = 0,
  parameter int ADDR_WIDTH      = 16,
  parameter int OUTPUT_ROUNDING = 0,
  parameter int OUT_WIDTH       = 17,
  parameter int OUT_FRAC_WIDTH  = 0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [M*K*Y_WIDTH-1:0]         y_data,
  input  logic                           y_valid,
  output logic                           y_ready,
  input  logic [X_WIDTH-1:0]             x_data,
  input  logic [ADDR_WIDTH-1:0]          x_row,
  input  logic [ADDR_WIDTH-1:0]          x_col,
  input  logic                           x_last,
  input  logic                           x_valid,
  output logic                           x_ready,
  output logic [N*K*OUT_WIDTH-1:0]       out_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           idx_err
);

  localparam int ACC_WIDTH      = X_WIDTH + Y_WIDTH + $clog2(M);
  localparam int ACC_FRAC_WIDTH = X_FRAC_WIDTH + Y_FRAC_WIDTH;
  localparam int PW             = X_WIDTH + Y_WIDTH;
  localparam int SH             = ACC_FRAC_WIDTH - OUT_FRAC_WIDTH;
  localparam int SHR            = (SH > 0) ? SH : 0;
  localparam int SHL            = (SH < 0) ? -SH : 0;
  localparam int RW             = ACC_WIDTH + OUT_WIDTH + SHL + 2;

  typedef enum logic [1:0] {IDLE, ACCUM, FLUSH} state_t;

  state_t                       state_q, state_d;
  logic signed [ACC_WIDTH-1:0]  acc_q [N*K];
  logic signed [ACC_WIDTH-1:0]  acc_d [N*K];
  logic signed [Y_WIDTH-1:0]    y_q   [M*K];
  logic signed [Y_WIDTH-1:0]    ysel  [K];
  logic signed [PW-1:0]         prod  [K];
  logic [ADDR_WIDTH-1:0]        r_sel, c_sel;
  logic                         x_fire, y_fire, acc_en;

  // Round half-up from the accumulator binary point to the output one, then saturate.
  function automatic logic signed [OUT_WIDTH-1:0] fixed_round(input logic signed [ACC_WIDTH-1:0] a);
    logic signed [RW-1:0] t, maxv, minv;
    maxv = RW'((64'sd1 <<< (OUT_WIDTH - 1)) - 64'sd1);
    minv = -maxv - RW'(1);
    t = RW'(a);
    t = (t <<< SHL) + RW'((64'sd1 <<< SHR) >>> 1);
    t = t >>> SHR;
    if (t > maxv)      t = maxv;
    else if (t < minv) t = minv;
    return t[OUT_WIDTH-1:0];
  endfunction

  always_comb begin
    state_d   = state_q;
    y_ready   = 1'b0;
    x_ready   = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        y_ready = rst_n;
        if (y_valid && rst_n) state_d = ACCUM;
      end
      ACCUM: begin
        x_ready = 1'b1;
        if (x_valid && x_last) state_d = FLUSH;
      end
      FLUSH: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign x_fire = x_valid && x_ready;
  assign y_fire = y_valid && y_ready;
  // Indices fold into range so an illegal entry can never address outside the bank.
  assign r_sel  = x_row % ADDR_WIDTH'(N);
  assign c_sel  = x_col % ADDR_WIDTH'(M);

`ifdef COO_STREAM_MATMUL_IDX_CHECK_EN
  logic in_range;
  logic idx_err_q;
  assign in_range = (x_row < ADDR_WIDTH'(N)) && (x_col < ADDR_WIDTH'(M));
  assign acc_en   = x_fire && in_range;
  assign idx_err  = idx_err_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    idx_err_q <= 1'b0;
    else if (x_fire && !in_range)  idx_err_q <= 1'b1;
  end
`else
  assign acc_en  = x_fire;
  assign idx_err = 1'b0;
`endif

  always_comb begin
    for (int j = 0; j < K; j++) begin
      ysel[j] = '0;
      for (int m = 0; m < M; m++)
        if (c_sel == ADDR_WIDTH'(m)) ysel[j] = y_q[m*K+j];
      prod[j] = $signed(x_data) * ysel[j];
    end
  end

  always_comb begin
    for (int i = 0; i < N*K; i++) acc_d[i] = acc_q[i];
    if (y_fire) begin
      for (int i = 0; i < N*K; i++) acc_d[i] = '0;
    end else if (acc_en) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < K; j++)
          if (r_sel == ADDR_WIDTH'(i)) acc_d[i*K+j] = acc_q[i*K+j] + ACC_WIDTH'(prod[j]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      for (int i = 0; i < N*K; i++) acc_q[i] <= '0;
      for (int i = 0; i < M*K; i++) y_q[i]   <= '0;
    end else begin
      state_q <= state_d;
      for (int i = 0; i < N*K; i++) acc_q[i] <= acc_d[i];
      if (y_fire)
        for (int i = 0; i < M*K; i++) y_q[i] <= y_data[i*Y_WIDTH +: Y_WIDTH];
    end
  end

  if (OUTPUT_ROUNDING == 0 && (OUT_WIDTH != ACC_WIDTH || OUT_FRAC_WIDTH != ACC_FRAC_WIDTH)) begin : g_bad_cfg
    $fatal(1, "coo_stream_matmul: without rounding OUT widths must equal ACC widths");
  end

  for (genvar g = 0; g < N*K; g++) begin : g_out
    if (OUTPUT_ROUNDING != 0) begin : g_rnd
      assign out_data[g*OUT_WIDTH +: OUT_WIDTH] = fixed_round(acc_q[g]);
    end else begin : g_raw
      assign out_data[g*OUT_WIDTH +: OUT_WIDTH] = acc_q[g];
    end
  end

endmodule

// File: tb/tb_coo_stream_matmul.sv
// Bench for coo_stream_matmul: directed cases plus random matrices checked through a result scoreboard.
module tb_coo_stream_matmul;

  localparam int N = 2, M = 2, K = 2, XW = 8, YW = 8, AW = 16, OW = 17;
  localparam int OV = N*K*OW;

  logic             clk = 1'b0, rst_n = 1'b0;
  logic [M*K*YW-1:0] y_data = '0;
  logic             y_valid = 1'b0, y_ready;
  logic [XW-1:0]    x_data = '0;
  logic [AW-1:0]    x_row = '0, x_col = '0;
  logic             x_last = 1'b0, x_valid = 1'b0, x_ready;
  logic [OV-1:0]    out_data;
  logic             out_valid, out_ready = 1'b0, idx_err;

  always #5 clk = ~clk;

  coo_stream_matmul #(.N(N), .M(M), .K(K), .X_WIDTH(XW), .Y_WIDTH(YW), .ADDR_WIDTH(AW),
                      .OUT_WIDTH(OW)) dut (
    .clk(clk), .rst_n(rst_n),
    .y_data(y_data), .y_valid(y_valid), .y_ready(y_ready),
    .x_data(x_data), .x_row(x_row), .x_col(x_col), .x_last(x_last),
    .x_valid(x_valid), .x_ready(x_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .idx_err(idx_err)
  );

  typedef struct packed { logic dc; logic [OV-1:0] data; } exp_t;
  exp_t sb_q[$];
  int   n_chk = 0, n_fail = 0;
  int   my[M*K];
  int   macc[N*K];
  logic dc_m = 1'b0;

  task automatic chk(input string tag, input logic [OV-1:0] got, input logic [OV-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [OV-1:0] pack4(input int a, input int b, input int c, input int d);
    logic [OV-1:0] r;
    r = {OW'(d), OW'(c), OW'(b), OW'(a)};
    return r;
  endfunction

  function automatic logic [OV-1:0] model_pack();
    logic [OV-1:0] r;
    for (int i = 0; i < N*K; i++) r[i*OW +: OW] = OW'(macc[i]);
    return r;
  endfunction

  task automatic cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_y(input int a, input int b, input int c, input int d);
    int   v[4];
    logic ok;
    v = '{a, b, c, d};
    for (int k = 0; k < M*K; k++) begin
      y_data[k*YW +: YW] = YW'(v[k]);
      my[k] = v[k];
    end
    for (int i = 0; i < N*K; i++) macc[i] = 0;
    y_valid = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 50; n++) begin
      if (y_ready) begin ok = 1'b1; @(posedge clk); #1; break; end
      @(posedge clk); #1;
    end
    y_valid = 1'b0;
    chk("y_handshake", ok, 1);
  endtask

  task automatic send_x(input int r, input int c, input int v, input logic last);
    logic ok;
    x_row = AW'(r); x_col = AW'(c); x_data = XW'(v); x_last = last; x_valid = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 50; n++) begin
      if (x_ready) begin ok = 1'b1; @(posedge clk); #1; break; end
      @(posedge clk); #1;
    end
    x_valid = 1'b0; x_last = 1'b0;
    chk("x_handshake", ok, 1);
    if (r < N && c < M) begin
      for (int j = 0; j < K; j++) macc[r*K+j] += v * my[c*K+j];
    end else begin
`ifndef COO_STREAM_MATMUL_IDX_CHECK_EN
      dc_m = 1'b1;
`endif
    end
    if (last) begin
      sb_q.push_back('{dc: dc_m, data: model_pack()});
      dc_m = 1'b0;
    end
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int n = 0; n < 50; n++) begin
      if (sb_q.size() == 0) break;
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
    chk("drain_done", OV'(sb_q.size()), 0);
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      chk("sb_nonempty", OV'(sb_q.size() != 0), 1);
      if (sb_q.size() != 0) begin
        exp_t e;
        e = sb_q.pop_front();
        if (!e.dc) chk("out_data", out_data, e.data);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    cycles(3);
    chk("rst_y_ready", y_ready, 0);
    chk("rst_x_ready", x_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_idx_err", idx_err, 0);
    rst_n = 1'b1;
    #1;
    chk("idle_y_ready", y_ready, 1);
    cycles(1);

    // basic, back-to-back entries
    send_y(1, 2, 3, 4);
    send_x(0, 0, 1, 1'b0);
    send_x(1, 1, 2, 1'b1);
    chk("basic_latency", out_valid, 1);
    chk("basic_val", out_data, pack4(1, 2, 6, 8));
    drain();

    // duplicates and signed values, then a second matrix
    send_y(1, 2, 3, 4);
    send_x(0, 1, 3, 1'b0);
    send_x(0, 1, -1, 1'b1);
    chk("dup_val", out_data, pack4(6, 8, 0, 0));
    drain();
    send_y(1, 2, 3, 4);
    send_x(1, 0, -2, 1'b1);
    chk("second_val", out_data, pack4(0, 0, -2, -4));
    drain();

    // output backpressure
    send_y(1, 2, 3, 4);
    send_x(0, 0, 1, 1'b0);
    send_x(1, 1, 2, 1'b1);
    for (int c = 0; c < 5; c++) begin
      chk("bp_out_valid", out_valid, 1);
      chk("bp_out_data", out_data, pack4(1, 2, 6, 8));
      chk("bp_x_ready", x_ready, 0);
      chk("bp_y_ready", y_ready, 0);
      cycles(1);
    end
    drain();
    chk("bp_idle_y_ready", y_ready, 1);
    chk("bp_idle_out_valid", out_valid, 0);

    // x_valid in IDLE is ignored; stalled entries still sum correctly
    x_row = '0; x_col = '0; x_data = XW'(50); x_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      chk("idle_x_ready", x_ready, 0);
      cycles(1);
    end
    x_valid = 1'b0;
    send_y(1, 2, 3, 4);
    send_x(0, 0, 1, 1'b0);
    cycles(1);
    send_x(1, 1, 2, 1'b1);
    chk("stall_val", out_data, pack4(1, 2, 6, 8));
    drain();

    // reset in the middle of accumulation
    send_y(1, 2, 3, 4);
    send_x(0, 0, 1, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_data", out_data, 0);
    chk("mid_rst_y_ready", y_ready, 0);
    chk("mid_rst_x_ready", x_ready, 0);
    chk("mid_rst_out_valid", out_valid, 0);
    cycles(2);
    rst_n = 1'b1;
    cycles(1);
    send_y(1, 2, 3, 4);
    send_x(0, 0, 1, 1'b0);
    send_x(1, 1, 2, 1'b1);
    chk("post_rst_val", out_data, pack4(1, 2, 6, 8));
    drain();

    // out-of-range index
    send_y(1, 2, 3, 4);
    send_x(2, 0, 5, 1'b0);
`ifdef COO_STREAM_MATMUL_IDX_CHECK_EN
    chk("idx_err_set", idx_err, 1);
    send_x(0, 0, 1, 1'b1);
    chk("idx_err_hold", idx_err, 1);
    chk("idx_val", out_data, pack4(1, 2, 0, 0));
    drain();
    chk("idx_err_sticky", idx_err, 1);
`else
    send_x(0, 0, 1, 1'b1);
    chk("idx_flush_reached", out_valid, 1);
    chk("idx_err_tied", idx_err, 0);
    drain();
`endif

    // random matrices with optional gaps between entries
    for (int t = 0; t < 25; t++) begin
      int ne;
      send_y(int'($urandom_range(255)) - 128, int'($urandom_range(255)) - 128,
             int'($urandom_range(255)) - 128, int'($urandom_range(255)) - 128);
      ne = int'($urandom_range(6, 1));
      for (int e = 0; e < ne; e++) begin
        send_x(int'($urandom_range(N-1)), int'($urandom_range(M-1)),
               int'($urandom_range(255)) - 128, e == ne - 1);
        if ($urandom_range(3) == 0) cycles(1);
      end
      chk("rand_latency", out_valid, 1);
      drain();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
